// File: rtl/axi_frame_writer_mb.sv
// AXI4 frame-buffer writer: packs a pixel stream into full bursts held on chip,
// writes frames into a rotating set of DDR buffers and publishes the last finished one.
module axi_frame_writer_mb #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 64,
    parameter int                PIX_W        = 16,
    parameter int                BURST_LEN    = 16,
    parameter int                NUM_BUF      = 3,
    parameter int                FRAME_PIXELS = 307200,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] BUF_STRIDE   = 32'h0010_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PIX_W-1:0]           s_pix_data,
    input  logic                       s_pix_valid,
    input  logic                       s_pix_sof,
    output logic                       s_pix_ready,
    input  logic [$clog2(NUM_BUF)-1:0] i_rd_buf,
    output logic [$clog2(NUM_BUF)-1:0] o_done_buf,
    output logic                       o_done_valid,
    output logic                       o_frame_done,
    output logic [15:0]                o_abort_cnt,
    output logic                       o_bresp_err,
    output logic [ADDR_W-1:0]          m_axi_awaddr,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic [DATA_W-1:0]          m_axi_wdata,
    output logic [DATA_W/8-1:0]        m_axi_wstrb,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    output logic                       m_axi_wlast,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready
);
    localparam int PPB         = DATA_W / PIX_W;
    localparam int BURSTS      = FRAME_PIXELS / (PPB * BURST_LEN);
    localparam int BURST_BYTES = BURST_LEN * (DATA_W / 8);
    localparam int BUF_W       = $clog2(NUM_BUF);
    localparam int K_W         = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int BT_W        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BI_W        = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    typedef enum logic [2:0] {WAIT_SOF, FILL, AW, W, B} state_t;

    state_t              state_q;
    logic [K_W-1:0]      k_q;
    logic [BT_W-1:0]     beat_q, rd_q;
    logic [BI_W-1:0]     burst_q;
    logic [BUF_W-1:0]    wr_buf_q, done_buf_q;
    logic [DATA_W-1:0]   acc_q, wdata_q;
    logic [DATA_W-1:0]   mem_q [BURST_LEN];
    logic [ADDR_W-1:0]   awaddr_q;
    logic [15:0]         abort_q;
    logic                ready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic                done_q, done_valid_q, err_q;

    logic                take_s, early_s, beat_full_s, burst_full_s;
    logic [K_W-1:0]      k_d;
    logic [BT_W-1:0]     beat_d, rd_nx_s;
    logic [BI_W-1:0]     burst_d;
    logic [DATA_W-1:0]   acc_d;
    logic [ADDR_W-1:0]   awaddr_d;
    logic [BUF_W-1:0]    nb1_s, nb_s;

    function automatic logic [BUF_W-1:0] inc_buf(input logic [BUF_W-1:0] b);
        return (b == BUF_W'(NUM_BUF - 1)) ? '0 : b + BUF_W'(1);
    endfunction

    // Pixel acceptance and packing; any accepted SOF restarts the frame at pixel 0.
    always_comb begin
        take_s       = s_pix_valid && ready_q &&
                       ((state_q == FILL) || ((state_q == WAIT_SOF) && s_pix_sof));
        early_s      = take_s && (state_q == FILL) && s_pix_sof &&
                       ((burst_q != '0) || (beat_q != '0) || (k_q != '0));
        k_d          = s_pix_sof ? '0 : k_q;
        beat_d       = s_pix_sof ? '0 : beat_q;
        burst_d      = s_pix_sof ? '0 : burst_q;
        acc_d        = acc_q;
        acc_d[PIX_W*k_d +: PIX_W] = s_pix_data;
        beat_full_s  = (k_d == K_W'(PPB - 1));
        burst_full_s = beat_full_s && (beat_d == BT_W'(BURST_LEN - 1));
        awaddr_d     = BASE_ADDR + ADDR_W'(wr_buf_q) * BUF_STRIDE
                       + ADDR_W'(burst_d) * ADDR_W'(BURST_BYTES);
        rd_nx_s      = rd_q + BT_W'(1);
        nb1_s        = inc_buf(wr_buf_q);
        nb_s         = (nb1_s == i_rd_buf) ? inc_buf(nb1_s) : nb1_s;
    end

    // Burst store: filled beat by beat while packing, drained only during W.
    always_ff @(posedge clk) begin
        if (take_s && beat_full_s) begin
            mem_q[beat_d] <= acc_d;
        end
    end

    // Main controller with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_SOF;
            k_q          <= '0;
            beat_q       <= '0;
            rd_q         <= '0;
            burst_q      <= '0;
            wr_buf_q     <= '0;
            done_buf_q   <= '0;
            acc_q        <= '0;
            wdata_q      <= '0;
            awaddr_q     <= '0;
            abort_q      <= 16'h0000;
            ready_q      <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            bready_q     <= 1'b0;
            done_q       <= 1'b0;
            done_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                WAIT_SOF, FILL: begin
                    ready_q <= 1'b1;
                    if (take_s) begin
                        acc_q   <= acc_d;
                        burst_q <= burst_d;
                        k_q     <= beat_full_s ? '0 : k_d + K_W'(1);
                        if (early_s && (abort_q != 16'hFFFF)) begin
                            abort_q <= abort_q + 16'h0001;
                        end
                        if (burst_full_s) begin
                            beat_q    <= '0;
                            state_q   <= AW;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= awaddr_d;
                            ready_q   <= 1'b0;
                        end else begin
                            beat_q  <= beat_full_s ? beat_d + BT_W'(1) : beat_d;
                            state_q <= FILL;
                        end
                    end
                end
                AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= mem_q[0];
                        wlast_q   <= (BURST_LEN == 1);
                        rd_q      <= '0;
                        state_q   <= W;
                    end
                end
                W: begin
                    if (m_axi_wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= B;
                        end else begin
                            rd_q    <= rd_nx_s;
                            wdata_q <= mem_q[rd_nx_s];
                            wlast_q <= (rd_nx_s == BT_W'(BURST_LEN - 1));
                        end
                    end
                end
                B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        if (m_axi_bresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (burst_q == BI_W'(BURSTS - 1)) begin
                            done_q       <= 1'b1;
                            done_buf_q   <= wr_buf_q;
                            done_valid_q <= 1'b1;
                            wr_buf_q     <= nb_s;
                            burst_q      <= '0;
                            state_q      <= WAIT_SOF;
                        end else begin
                            burst_q <= burst_q + BI_W'(1);
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= WAIT_SOF;
            endcase
        end
    end

    assign s_pix_ready   = ready_q;
    assign o_done_buf    = done_buf_q;
    assign o_done_valid  = done_valid_q;
    assign o_frame_done  = done_q;
    assign o_abort_cnt   = abort_q;
    assign o_bresp_err   = err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(DATA_W / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_bready  = bready_q;
endmodule

// File: tb/tb_axi_frame_writer_mb.sv
// Directed bench for axi_frame_writer_mb: a table of whole frames plus abort and reset sequences.
module tb_axi_frame_writer_mb;
    logic        clk, rst;
    logic [15:0] s_pix_data;
    logic        s_pix_valid, s_pix_sof, s_pix_ready;
    logic [1:0]  i_rd_buf, o_done_buf;
    logic        o_done_valid, o_frame_done, o_bresp_err;
    logic [15:0] o_abort_cnt;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid, m_axi_awready;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    axi_frame_writer_mb #(
        .ADDR_W(32), .DATA_W(64), .PIX_W(16), .BURST_LEN(4), .NUM_BUF(3),
        .FRAME_PIXELS(128), .BASE_ADDR(32'h1000_0000), .BUF_STRIDE(32'h0010_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_sof(s_pix_sof),
        .s_pix_ready(s_pix_ready), .i_rd_buf(i_rd_buf), .o_done_buf(o_done_buf),
        .o_done_valid(o_done_valid), .o_frame_done(o_frame_done),
        .o_abort_cnt(o_abort_cnt), .o_bresp_err(o_bresp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_wlast(m_axi_wlast),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Slave/monitor state, written only by the negedge process below.
    logic [31:0] aw_addr_q [$];
    logic [63:0] w_data_q [$];
    logic        w_last_q [$];
    logic [7:0]  last_awlen;
    logic [2:0]  last_awsize;
    logic [1:0]  last_awburst;
    int aw_n = 0, w_n = 0, b_n = 0, done_n = 0;
    int aw_viol = 0, w_viol = 0, strb_bad = 0;
    int aw_wait = 0;
    bit aw_pend = 0, in_burst = 0, b_pend = 0;
    logic [1:0] done_buf_seen = 2'd0;

    // Knobs set by the stimulus between frames.
    bit w_toggle = 0;
    int aw_delay = 0;
    int err_b_at = -1;

    always @(negedge clk) begin
        if (rst) begin
            aw_wait = 0; aw_pend = 0; in_burst = 0; b_pend = 0;
            m_axi_awready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            if (m_axi_wready === 1'bx) m_axi_wready = 1'b1;
        end else begin
            if (aw_pend && !m_axi_awvalid) aw_viol++;
            if (m_axi_awvalid) begin
                aw_wait++;
                m_axi_awready = (aw_wait > aw_delay);
            end else begin
                aw_wait = 0;
                m_axi_awready = 1'b0;
            end
            aw_pend = m_axi_awvalid && !m_axi_awready;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_q.push_back(m_axi_awaddr);
                last_awlen = m_axi_awlen; last_awsize = m_axi_awsize; last_awburst = m_axi_awburst;
                aw_n++;
            end
            m_axi_bvalid = b_pend;
            m_axi_bresp  = (b_n == err_b_at) ? 2'b10 : 2'b00;
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 0;
                b_n++;
            end
            m_axi_wready = w_toggle ? ~m_axi_wready : 1'b1;
            if (in_burst && !m_axi_wvalid) w_viol++;
            if (m_axi_wvalid && m_axi_wready) begin
                w_data_q.push_back(m_axi_wdata);
                w_last_q.push_back(m_axi_wlast);
                if (m_axi_wstrb != 8'hFF) strb_bad++;
                in_burst = !m_axi_wlast;
                if (m_axi_wlast) b_pend = 1;
                w_n++;
            end
            if (o_frame_done) begin
                done_n++;
                done_buf_seen = o_done_buf;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_pix(input logic [15:0] d, input logic sof);
        int t = 0;
        @(negedge clk);
        s_pix_data = d; s_pix_valid = 1'b1; s_pix_sof = sof;
        while (!s_pix_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("pix_ready_timeout", 64'(t), 64'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        s_pix_valid = 1'b0; s_pix_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] seed, input int npix);
        for (int i = 0; i < npix; i++) push_pix(seed + 16'(i), (i == 0));
    endtask

    task automatic wait_frame(input int db);
        int t = 0;
        while (done_n <= db && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_timeout", 64'(done_n > db), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input int awb, input int wb, input int db, input logic [15:0] seed,
                               input logic [31:0] base, input logic [1:0] dbuf, input logic err);
        logic [31:0] lastpat;
        logic [15:0] p;
        chk("aw_count", 64'(aw_n - awb), 64'd8);
        if (aw_n - awb >= 8)
            for (int n = 0; n < 8; n++)
                chk("awaddr", 64'(aw_addr_q[awb+n]), 64'(base + 32'(n) * 32'h20));
        chk("awlen", 64'(last_awlen), 64'd3);
        chk("awsize", 64'(last_awsize), 64'd3);
        chk("awburst", 64'(last_awburst), 64'd1);
        chk("w_count", 64'(w_n - wb), 64'd32);
        lastpat = 32'h0;
        if (w_n - wb >= 32)
            for (int j = 0; j < 32; j++) begin
                p = seed + 16'(4 * j);
                chk("wdata", w_data_q[wb+j], {p + 16'd3, p + 16'd2, p + 16'd1, p});
                lastpat[j] = w_last_q[wb+j];
            end
        chk("wlast_pattern", 64'(lastpat), 64'h8888_8888);
        chk("frame_done_pulses", 64'(done_n - db), 64'd1);
        chk("done_buf", 64'(done_buf_seen), 64'(dbuf));
        chk("done_buf_out", 64'(o_done_buf), 64'(dbuf));
        chk("done_valid", 64'(o_done_valid), 64'd1);
        chk("bresp_err", 64'(o_bresp_err), 64'(err));
        chk("wvalid_gap", 64'(w_viol), 64'd0);
        chk("awvalid_drop", 64'(aw_viol), 64'd0);
        chk("wstrb", 64'(strb_bad), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  rd_buf;
        bit          wtog;
        int          aw_delay;
        int          err_burst;
        logic [15:0] seed;
        logic [31:0] base;
        logic [1:0]  dbuf;
        logic        err;
    } frame_vec_t;

    frame_vec_t vecs [4];

    initial begin
        int awb, wb, db;
        vecs[0] = '{2'd1, 1'b0, 0, -1, 16'h0000, 32'h1000_0000, 2'd0, 1'b0};
        vecs[1] = '{2'd2, 1'b1, 5, -1, 16'h0000, 32'h1020_0000, 2'd2, 1'b0};
        vecs[2] = '{2'd0, 1'b0, 0,  3, 16'h0040, 32'h1000_0000, 2'd0, 1'b1};
        vecs[3] = '{2'd0, 1'b0, 0, -1, 16'h5a00, 32'h1010_0000, 2'd1, 1'b1};

        rst = 1'b1; s_pix_data = 16'h0; s_pix_valid = 1'b0; s_pix_sof = 1'b0; i_rd_buf = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(s_pix_ready), 64'd0);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_wlast", 64'(m_axi_wlast), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_status", {o_frame_done, o_done_valid, o_done_buf, o_abort_cnt, o_bresp_err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(s_pix_ready), 64'd1);

        for (int v = 0; v < 4; v++) begin
            i_rd_buf = vecs[v].rd_buf;
            w_toggle = vecs[v].wtog;
            aw_delay = vecs[v].aw_delay;
            err_b_at = (vecs[v].err_burst < 0) ? -1 : b_n + vecs[v].err_burst;
            awb = aw_n; wb = w_n; db = done_n;
            send_frame(vecs[v].seed, 128);
            idle();
            wait_frame(db);
            check_frame(awb, wb, db, vecs[v].seed, vecs[v].base, vecs[v].dbuf, vecs[v].err);
        end
        w_toggle = 0; aw_delay = 0; err_b_at = -1; i_rd_buf = 2'd0;

        // Early SOF after 40 pixels, then a full frame.
        do_reset();
        chk("bresp_err_cleared", 64'(o_bresp_err), 64'd0);
        awb = aw_n; wb = w_n; db = done_n;
        send_frame(16'h0000, 40);
        for (int i = 0; i < 120; i++) push_pix(16'h0100 + 16'(i), (i == 0));
        chk("no_done_before_full", 64'(done_n - db), 64'd0);
        for (int i = 120; i < 128; i++) push_pix(16'h0100 + 16'(i), 1'b0);
        idle();
        wait_frame(db);
        chk("abort_cnt", 64'(o_abort_cnt), 64'd1);
        chk("aborted_bursts", 64'(aw_n - awb), 64'd10);
        check_frame(awb + 2, wb + 8, db, 16'h0100, 32'h1000_0000, 2'd0, 1'b0);

        // Reset landing on the W beat 2 handshake.
        awb = aw_n;
        send_frame(16'h0000, 16);
        idle();
        begin
            int t = 0;
            while (!(m_axi_wvalid && m_axi_wdata == 64'h000b_000a_0009_0008) && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("beat2_timeout", 64'(t < 200), 64'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("midrst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("midrst_ready", 64'(s_pix_ready), 64'd0);
        chk("midrst_done_valid", 64'(o_done_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        awb = aw_n;
        for (int i = 0; i < 5; i++) push_pix(16'h0300 + 16'(i), 1'b0);
        idle();
        repeat (20) @(negedge clk);
        chk("nonsof_dropped", 64'(aw_n - awb), 64'd0);
        chk("still_waiting_sof", 64'(s_pix_ready), 64'd1);
        awb = aw_n; wb = w_n; db = done_n;
        send_frame(16'h0200, 128);
        idle();
        wait_frame(db);
        check_frame(awb, wb, db, 16'h0200, 32'h1000_0000, 2'd0, 1'b0);
        chk("abort_after_rst", 64'(o_abort_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
